// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: shared memory port, execute redirect and the decode handshake.
// The fetch unit sits on the master side; the memory, execute and decode logic sit on the slave side.
interface instr_fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
);
  logic               mem_busy;
  logic [INSTR_W-1:0] imem_data;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               instr_ready;
  logic               fetch_req;
  logic [15:0]        fetch_addr;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic [3:0]         op_code;
  logic               instr_valid;
  logic               halted;

  modport master (
    input  mem_busy, imem_data, branch_taken, branch_target, instr_ready,
    output fetch_req, fetch_addr, pc, instr, op_code, instr_valid, halted
  );

  modport slave (
    output mem_busy, imem_data, branch_taken, branch_target, instr_ready,
    input  fetch_req, fetch_addr, pc, instr, op_code, instr_valid, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and reads one word at a time from the shared memory port.
// It hands each word to decode, and it handles branch redirects and HALT.
module instr_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 32,
  parameter int              MEM_LAT  = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      OP_HALT  = 4'b1111
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_unit_if.master   bus
);

  localparam int             LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t             state;
  logic [PC_W-1:0]    pc_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic               valid_reg;
  logic               halted_reg;
  logic               kill;
  logic [LAT_W-1:0]   lat_cnt;
  logic               data_return;

  assign data_return = (lat_cnt == '0);

  // A redirect in REQ suppresses the request so the stale PC never reaches memory.
  assign bus.fetch_req   = (state == S_REQ) && !bus.mem_busy && !bus.branch_taken;
  assign bus.fetch_addr  = 16'(pc_reg);
  assign bus.pc          = pc_reg;
  assign bus.instr       = instr_reg;
  assign bus.op_code     = instr_reg[INSTR_W-1 -: 4];
  assign bus.instr_valid = valid_reg;
  assign bus.halted      = halted_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc_reg     <= RESET_PC;
      instr_reg  <= '0;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
      kill       <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (bus.branch_taken) begin
            pc_reg <= bus.branch_target;
          end else if (!bus.mem_busy) begin
            lat_cnt <= LAT_INIT;
            state   <= S_WAIT;
          end
        end

        // A redirect while waiting must still let the outstanding read drain before refetching.
        S_WAIT: begin
          if (!data_return) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
          if (bus.branch_taken) begin
            pc_reg <= bus.branch_target;
            if (data_return) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              kill <= 1'b1;
            end
          end else if (data_return) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              instr_reg <= bus.imem_data;
              valid_reg <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (bus.branch_taken) begin
            pc_reg    <= bus.branch_target;
            valid_reg <= 1'b0;
            state     <= S_REQ;
          end else if (bus.instr_ready) begin
            valid_reg <= 1'b0;
            if (bus.op_code == OP_HALT) begin
              halted_reg <= 1'b1;
              state      <= S_HALT;
            end else begin
              pc_reg <= pc_reg + 1'b1;
              state  <= S_REQ;
            end
          end
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: table-driven cycle vectors at MEM_LAT=1, plus hand-written sequences
// for reset mid-fetch and for a redirect on a MEM_LAT=3 instance.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   total_cnt;
  int   pass_cnt;

  instr_fetch_unit_if #(.PC_W(8), .INSTR_W(32)) ifc  ();
  instr_fetch_unit_if #(.PC_W(8), .INSTR_W(32)) ifc3 ();

  instr_fetch_unit #(.MEM_LAT(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  instr_fetch_unit #(.MEM_LAT(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc3.master)
  );

  typedef struct {
    logic        busy;
    logic [31:0] data;
    logic        br;
    logic [7:0]  tgt;
    logic        rdy;
    logic        e_req;
    logic [7:0]  e_pc;
    logic        e_valid;
    logic [3:0]  e_op;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic add(input logic busy, input logic [31:0] data, input logic br, input logic [7:0] tgt,
                     input logic rdy, input logic e_req, input logic [7:0] e_pc, input logic e_valid,
                     input logic [3:0] e_op, input logic e_halt);
    vec_t v;
    v.busy = busy; v.data = data; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid; v.e_op = e_op; v.e_halt = e_halt;
    vecs.push_back(v);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic apply_stimulus(input vec_t v);
    ifc.mem_busy      = v.busy;
    ifc.imem_data     = v.data;
    ifc.branch_taken  = v.br;
    ifc.branch_target = v.tgt;
    ifc.instr_ready   = v.rdy;
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check_eq($sformatf("row%0d fetch_req", idx), 32'(ifc.fetch_req), 32'(v.e_req));
    if (v.e_req) check_eq($sformatf("row%0d fetch_addr", idx), 32'(ifc.fetch_addr), {24'h0, v.e_pc});
    check_eq($sformatf("row%0d pc", idx), 32'(ifc.pc), 32'(v.e_pc));
    check_eq($sformatf("row%0d instr_valid", idx), 32'(ifc.instr_valid), 32'(v.e_valid));
    if (v.e_valid) check_eq($sformatf("row%0d op_code", idx), 32'(ifc.op_code), 32'(v.e_op));
    check_eq($sformatf("row%0d halted", idx), 32'(ifc.halted), 32'(v.e_halt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;

    //   busy data          br tgt    rdy | req pc     valid op    halt
    add(0, 32'hD1000000, 0, 8'h00, 1,   1, 8'h00, 0, 4'h0, 0);
    add(0, 32'hD1000000, 0, 8'h00, 1,   0, 8'h00, 0, 4'h0, 0);
    add(0, 32'h00000000, 0, 8'h00, 1,   0, 8'h00, 1, 4'hD, 0);
    add(1, 32'h00000000, 0, 8'h00, 1,   0, 8'h01, 0, 4'h0, 0);
    add(1, 32'h00000000, 0, 8'h00, 1,   0, 8'h01, 0, 4'h0, 0);
    add(1, 32'h00000000, 0, 8'h00, 1,   0, 8'h01, 0, 4'h0, 0);
    add(0, 32'h00000000, 0, 8'h00, 1,   1, 8'h01, 0, 4'h0, 0);
    add(0, 32'h2A000011, 0, 8'h00, 0,   0, 8'h01, 0, 4'h0, 0);
    add(1, 32'h00000000, 0, 8'h00, 0,   0, 8'h01, 1, 4'h2, 0);
    add(0, 32'h00000000, 0, 8'h00, 0,   0, 8'h01, 1, 4'h2, 0);
    add(0, 32'h00000000, 0, 8'h00, 0,   0, 8'h01, 1, 4'h2, 0);
    add(1, 32'h00000000, 0, 8'h00, 0,   0, 8'h01, 1, 4'h2, 0);
    add(0, 32'h00000000, 0, 8'h00, 1,   0, 8'h01, 1, 4'h2, 0);
    add(0, 32'h00000000, 0, 8'h00, 1,   1, 8'h02, 0, 4'h0, 0);
    add(0, 32'h3B000000, 1, 8'h40, 1,   0, 8'h02, 0, 4'h0, 0);
    add(0, 32'h00000000, 0, 8'h00, 1,   1, 8'h40, 0, 4'h0, 0);
    add(0, 32'h4C000000, 0, 8'h00, 1,   0, 8'h40, 0, 4'h0, 0);
    add(0, 32'h00000000, 0, 8'h00, 1,   0, 8'h40, 1, 4'h4, 0);
    add(0, 32'h00000000, 1, 8'h05, 1,   0, 8'h41, 0, 4'h0, 0);
    add(0, 32'h00000000, 0, 8'h00, 1,   1, 8'h05, 0, 4'h0, 0);
    add(0, 32'h5E000000, 0, 8'h00, 1,   0, 8'h05, 0, 4'h0, 0);
    add(0, 32'h00000000, 1, 8'h10, 1,   0, 8'h05, 1, 4'h5, 0);
    add(0, 32'h00000000, 0, 8'h00, 1,   1, 8'h10, 0, 4'h0, 0);
    add(0, 32'h60000000, 0, 8'h00, 1,   0, 8'h10, 0, 4'h0, 0);
    add(0, 32'h00000000, 1, 8'hFF, 0,   0, 8'h10, 1, 4'h6, 0);
    add(0, 32'h00000000, 0, 8'h00, 1,   1, 8'hFF, 0, 4'h0, 0);
    add(0, 32'h71000000, 0, 8'h00, 1,   0, 8'hFF, 0, 4'h0, 0);
    add(0, 32'h00000000, 0, 8'h00, 1,   0, 8'hFF, 1, 4'h7, 0);
    add(0, 32'h00000000, 0, 8'h00, 1,   1, 8'h00, 0, 4'h0, 0);
    add(0, 32'hF0000000, 0, 8'h00, 1,   0, 8'h00, 0, 4'h0, 0);
    add(0, 32'h00000000, 0, 8'h00, 0,   0, 8'h00, 1, 4'hF, 0);
    add(0, 32'h00000000, 0, 8'h00, 1,   0, 8'h00, 1, 4'hF, 0);
    add(0, 32'h00000000, 1, 8'h33, 1,   0, 8'h00, 0, 4'h0, 1);
    add(0, 32'h00000000, 0, 8'h00, 1,   0, 8'h00, 0, 4'h0, 1);

    ifc.mem_busy = 0; ifc.imem_data = '0; ifc.branch_taken = 0; ifc.branch_target = '0; ifc.instr_ready = 0;
    ifc3.mem_busy = 0; ifc3.imem_data = '0; ifc3.branch_taken = 0; ifc3.branch_target = '0; ifc3.instr_ready = 0;

    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check_eq("reset pc", 32'(ifc.pc), 32'h00);
    check_eq("reset instr_valid", 32'(ifc.instr_valid), 32'h0);
    check_eq("reset halted", 32'(ifc.halted), 32'h0);
    check_eq("reset instr", ifc.instr, 32'h0);
    tick();
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output(vecs[i], i);
      tick();
    end

    // Reset out of HALT, then reset again while a read is in flight.
    ifc.branch_taken = 0; ifc.instr_ready = 1; ifc.mem_busy = 0; ifc.imem_data = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("post-halt reset halted", 32'(ifc.halted), 32'h0);
    check_eq("post-halt reset pc", 32'(ifc.pc), 32'h00);
    check_eq("post-halt fetch_req", 32'(ifc.fetch_req), 32'h1);
    tick();
    ifc.imem_data = 32'hD1000000;
    @(negedge clk);
    check_eq("wait fetch_req", 32'(ifc.fetch_req), 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid-wait reset instr_valid", 32'(ifc.instr_valid), 32'h0);
    check_eq("mid-wait reset pc", 32'(ifc.pc), 32'h00);
    check_eq("mid-wait reset fetch_req", 32'(ifc.fetch_req), 32'h1);
    tick();
    ifc.imem_data = 32'h92000000;
    @(negedge clk);
    check_eq("refetch wait instr_valid", 32'(ifc.instr_valid), 32'h0);
    tick();
    @(negedge clk);
    check_eq("refetch instr_valid", 32'(ifc.instr_valid), 32'h1);
    check_eq("refetch op_code", 32'(ifc.op_code), 32'h9);

    // MEM_LAT=3 instance: redirect early in WAIT must discard the late return.
    ifc3.instr_ready = 1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("lat3 c0 fetch_req", 32'(ifc3.fetch_req), 32'h1);
    tick();
    ifc3.branch_taken = 1; ifc3.branch_target = 8'h40;
    @(negedge clk);
    check_eq("lat3 c1 fetch_req", 32'(ifc3.fetch_req), 32'h0);
    tick();
    ifc3.branch_taken = 0; ifc3.branch_target = 8'h00;
    @(negedge clk);
    check_eq("lat3 c2 pc", 32'(ifc3.pc), 32'h40);
    check_eq("lat3 c2 fetch_req", 32'(ifc3.fetch_req), 32'h0);
    tick();
    ifc3.imem_data = 32'h77000000;
    @(negedge clk);
    check_eq("lat3 c3 instr_valid", 32'(ifc3.instr_valid), 32'h0);
    tick();
    ifc3.imem_data = '0;
    @(negedge clk);
    check_eq("lat3 c4 instr_valid", 32'(ifc3.instr_valid), 32'h0);
    check_eq("lat3 c4 fetch_req", 32'(ifc3.fetch_req), 32'h1);
    check_eq("lat3 c4 fetch_addr", 32'(ifc3.fetch_addr), 32'h0040);
    for (int c = 5; c <= 7; c++) begin
      tick();
      if (c == 7) ifc3.imem_data = 32'h8A000000;
      @(negedge clk);
      check_eq($sformatf("lat3 c%0d instr_valid", c), 32'(ifc3.instr_valid), 32'h0);
    end
    tick();
    @(negedge clk);
    check_eq("lat3 c8 instr_valid", 32'(ifc3.instr_valid), 32'h1);
    check_eq("lat3 c8 op_code", 32'(ifc3.op_code), 32'h8);
    check_eq("lat3 c8 pc", 32'(ifc3.pc), 32'h40);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
